// File: rtl/bpu_ctrl.sv
// Fetch-stage branch predictor (2-bit counters + tagged BTB) and decode-stage
// redirect controller that compares the carried prediction against the resolved outcome.
module bpu_ctrl #(
    parameter int         IDX_W    = 4,
    parameter int         TAG_W    = 26,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_F,
    output logic        pred_taken_F,
    output logic [31:0] pred_target_F,
    input  logic        stall_D,
    input  logic        flush_D,
    input  logic        instr_valid_D,
    input  logic        ctrl_valid_D,
    input  logic [31:0] pc_D,
    input  logic        taken_D,
    input  logic [31:0] target_D,
    output logic        mispredict_D,
    output logic [31:0] redirect_pc_D
);
    localparam int ENTRIES = 2 ** IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [1:0]         cnt_q [ENTRIES];

    logic               pred_taken_q;
    logic [31:0]        pred_target_q;

    logic [IDX_W-1:0]   idx_f;
    logic [IDX_W-1:0]   idx_d;
    logic [TAG_W-1:0]   tag_f;
    logic [TAG_W-1:0]   tag_d;
    logic               hit_f;
    logic               hit_d;
    logic [31:0]        pc_f_plus4;
    logic [31:0]        pc_d_plus4;
    logic               actual_taken;
    logic               mismatch;
    logic               train_en;
    logic               unused_pc_bits;

    assign idx_f = pc_F[IDX_W+1:2];
    assign idx_d = pc_D[IDX_W+1:2];
    assign tag_f = pc_F[IDX_W+1+TAG_W:IDX_W+2];
    assign tag_d = pc_D[IDX_W+1+TAG_W:IDX_W+2];
    assign unused_pc_bits = ^{pc_F[1:0], pc_D[1:0]};

    assign pc_f_plus4 = pc_F + 32'd4;
    assign pc_d_plus4 = pc_D + 32'd4;

    // Lookup reads the registered table, so a same-cycle update is seen next cycle.
    assign hit_f         = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_d         = valid_q[idx_d] && (tag_q[idx_d] == tag_d);
    assign pred_taken_F  = hit_f & cnt_q[idx_f][1];
    assign pred_target_F = pred_taken_F ? tgt_q[idx_f] : pc_f_plus4;

    // A non-control instruction counts as not taken, so a stale "taken" alias redirects to pc_D+4.
    assign actual_taken  = ctrl_valid_D & taken_D;
    assign mismatch      = instr_valid_D &
                           ((pred_taken_q != actual_taken) |
                            (pred_taken_q & actual_taken & (pred_target_q != target_D)));
    assign mispredict_D  = rst_n & mismatch & ~stall_D;
    assign redirect_pc_D = (rst_n & actual_taken) ? target_D : pc_d_plus4;
    assign train_en      = instr_valid_D & ctrl_valid_D & ~stall_D & ~flush_D;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_taken_q  <= 1'b0;
            pred_target_q <= 32'd0;
        end else if (flush_D || mispredict_D) begin
            pred_taken_q  <= 1'b0;
            pred_target_q <= 32'd0;
        end else if (!stall_D) begin
            pred_taken_q  <= pred_taken_F;
            pred_target_q <= pred_target_F;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= 32'd0;
                cnt_q[i] <= CNT_INIT;
            end
        end else if (train_en) begin
            if (hit_d) begin
                if (taken_D) begin
                    tgt_q[idx_d] <= target_D;
                    if (cnt_q[idx_d] != 2'b11) cnt_q[idx_d] <= cnt_q[idx_d] + 2'd1;
                end else if (cnt_q[idx_d] != 2'b00) begin
                    cnt_q[idx_d] <= cnt_q[idx_d] - 2'd1;
                end
            end else if (taken_D) begin
                // Only taken branches allocate; a not-taken miss already predicts correctly.
                valid_q[idx_d] <= 1'b1;
                tag_q[idx_d]   <= tag_d;
                tgt_q[idx_d]   <= target_D;
                cnt_q[idx_d]   <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_bpu_ctrl.sv
// Directed bench for bpu_ctrl: lookup, training, hysteresis, stall hold, alias and flush.
module tb_bpu_ctrl;
    logic        clk;
    logic        rst_n;
    logic [31:0] pc_F;
    logic        pred_taken_F;
    logic [31:0] pred_target_F;
    logic        stall_D;
    logic        flush_D;
    logic        instr_valid_D;
    logic        ctrl_valid_D;
    logic [31:0] pc_D;
    logic        taken_D;
    logic [31:0] target_D;
    logic        mispredict_D;
    logic [31:0] redirect_pc_D;

    int          n_cmp;
    int          n_err;
    logic [31:0] exp_q[$];

    bpu_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_F          (pc_F),
        .pred_taken_F  (pred_taken_F),
        .pred_target_F (pred_target_F),
        .stall_D       (stall_D),
        .flush_D       (flush_D),
        .instr_valid_D (instr_valid_D),
        .ctrl_valid_D  (ctrl_valid_D),
        .pc_D          (pc_D),
        .taken_D       (taken_D),
        .target_D      (target_D),
        .mispredict_D  (mispredict_D),
        .redirect_pc_D (redirect_pc_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow a further settle delay.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic d_idle();
        instr_valid_D = 1'b0;
        ctrl_valid_D  = 1'b0;
        taken_D       = 1'b0;
        stall_D       = 1'b0;
        flush_D       = 1'b0;
        pc_D          = 32'h300;
        target_D      = 32'h0;
    endtask

    task automatic d_set(input logic ctrl, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt);
        instr_valid_D = 1'b1;
        ctrl_valid_D  = ctrl;
        pc_D          = pc;
        taken_D       = tk;
        target_D      = tgt;
    endtask

    task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        pc_F = 32'h500;
        d_set(1'b1, pc, tk, tgt);
        step();
        d_idle();
    endtask

    task automatic probe(input string tag, input logic [31:0] pc, input logic exp_tk,
                         input logic [31:0] exp_tgt);
        pc_F = pc;
        #1;
        check({tag, "_taken"}, {31'd0, pred_taken_F}, {31'd0, exp_tk});
        check({tag, "_target"}, pred_target_F, exp_tgt);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset: a taken control instruction in D must not redirect while held in reset.
        rst_n = 1'b0;
        d_idle();
        pc_F = 32'h100;
        d_set(1'b1, 32'h300, 1'b1, 32'h40);
        #2;
        check("rst_pred_taken", {31'd0, pred_taken_F}, 32'd0);
        check("rst_pred_target", pred_target_F, 32'h104);
        check("rst_mispredict", {31'd0, mispredict_D}, 32'd0);
        check("rst_redirect", redirect_pc_D, 32'h304);
        @(negedge clk);
        rst_n = 1'b1;
        d_set(1'b0, 32'h300, 1'b0, 32'h0);
        step();
        #1;
        check("post_rst_mispredict", {31'd0, mispredict_D}, 32'd0);
        check("post_rst_redirect", redirect_pc_D, 32'h304);
        d_idle();
        probe("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Cold miss: taken branch not predicted; table read in the same cycle is pre-update.
        pc_F = 32'h100;
        d_set(1'b1, 32'h100, 1'b1, 32'h80);
        #1;
        check("cold_mispredict", {31'd0, mispredict_D}, 32'd1);
        check("cold_redirect", redirect_pc_D, 32'h80);
        check("cold_same_cycle_read", {31'd0, pred_taken_F}, 32'd0);
        step();
        d_idle();
        probe("cold_trained", 32'h100, 1'b1, 32'h80);

        // Hysteresis: 10 -> 11 (saturate) -> 10 -> 01 -> 00 (saturate) -> 01 -> 10.
        repeat (3) train(32'h100, 1'b1, 32'h80);
        train(32'h100, 1'b0, 32'h0);
        probe("sat_nt1", 32'h100, 1'b1, 32'h80);
        train(32'h100, 1'b0, 32'h0);
        probe("sat_nt2", 32'h100, 1'b0, 32'h104);
        repeat (2) train(32'h100, 1'b0, 32'h0);
        train(32'h100, 1'b1, 32'h80);
        probe("sat_floor", 32'h100, 1'b0, 32'h104);
        train(32'h100, 1'b1, 32'h80);
        probe("sat_back", 32'h100, 1'b1, 32'h80);

        // Target change on a predicted-taken hit.
        pc_F = 32'h100;
        step();
        pc_F = 32'h500;
        d_set(1'b1, 32'h100, 1'b1, 32'hC0);
        #1;
        check("tgt_mispredict", {31'd0, mispredict_D}, 32'd1);
        check("tgt_redirect", redirect_pc_D, 32'hC0);
        step();
        d_idle();
        probe("tgt_btb", 32'h100, 1'b1, 32'hC0);
        step();
        d_set(1'b1, 32'h100, 1'b1, 32'hC0);
        #1;
        check("tgt_correct", {31'd0, mispredict_D}, 32'd0);
        step();
        d_idle();

        // Stall hold: mismatch suppressed for 3 cycles, then exactly one redirect.
        pc_F = 32'h100;
        step();
        repeat (3) exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        pc_F = 32'h500;
        d_set(1'b1, 32'h100, 1'b0, 32'h0);
        stall_D = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_mispredict", {31'd0, mispredict_D}, exp_q.pop_front());
            step();
        end
        stall_D = 1'b0;
        pc_F = 32'h100;
        #1;
        check("stall_release", {31'd0, mispredict_D}, exp_q.pop_front());
        check("stall_redirect", redirect_pc_D, 32'h104);
        step();
        pc_F = 32'h500;
        d_set(1'b0, 32'h104, 1'b0, 32'h0);
        #1;
        check("stall_one_pulse", {31'd0, mispredict_D}, exp_q.pop_front());
        step();
        d_idle();
        probe("stall_one_train", 32'h100, 1'b1, 32'hC0);
        train(32'h100, 1'b0, 32'h0);
        probe("stall_after", 32'h100, 1'b0, 32'h104);

        // Alias: predicted taken record, but D holds a non-control instruction.
        train(32'h100, 1'b1, 32'hC0);
        pc_F = 32'h100;
        step();
        pc_F = 32'h500;
        d_set(1'b0, 32'h200, 1'b0, 32'h0);
        #1;
        check("alias_mispredict", {31'd0, mispredict_D}, 32'd1);
        check("alias_redirect", redirect_pc_D, 32'h204);
        step();
        d_idle();

        // Flush clears the record and blocks training.
        pc_F = 32'h100;
        step();
        flush_D = 1'b1;
        step();
        pc_F = 32'h500;
        d_set(1'b1, 32'h100, 1'b0, 32'h0);
        #1;
        check("flush_cleared", {31'd0, mispredict_D}, 32'd0);
        step();
        d_idle();
        probe("flush_no_train", 32'h100, 1'b1, 32'hC0);

        // Asynchronous reset mid-operation wipes the table immediately.
        rst_n = 1'b0;
        #1;
        check("async_rst_taken", {31'd0, pred_taken_F}, 32'd0);
        check("async_rst_target", pred_target_F, 32'h104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
